// File: rtl/jtframe_upi_mbox.sv
// UPI-41/8742-style host mailbox with per-direction FIFOs and an MCU user status field.
// Define JTFRAME_UPI_MBOX_IRQ_EN to add the host_irq/mcu_irq outputs.
module jtframe_upi_mbox #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned STW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          a0,
  input  logic          cs_n,
  input  logic          cpu_rdn,
  input  logic          cpu_wrn,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  input  logic          mcu_rd,
  output logic [DW-1:0] mcu_dout,
  output logic          mcu_cmd,
  output logic          mcu_ibf,
  input  logic          mcu_wr,
  input  logic [DW-1:0] mcu_din,
  output logic          mcu_obf,
  input  logic          mcu_f0,
  input  logic [STW-1:0] mcu_st,
`ifdef JTFRAME_UPI_MBOX_IRQ_EN
  output logic          host_irq,
  output logic          mcu_irq,
`endif
  output logic          ovf
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (32'(p) == DEPTH - 1) return '0;
    return p + AW'(1);
  endfunction

  // Host strobe sampling and edge detection
  logic r_csn, r_a0;
  logic r_rdn_s, r_rdn_d, r_rd_hi, r_rd_arm;
  logic r_wrn_s, r_wrn_d, r_wr_hi, r_wr_arm;
  logic w_rd_edge, w_wr_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_csn    <= 1'b1;
      r_a0     <= 1'b0;
      r_rdn_s  <= 1'b1;
      r_rdn_d  <= 1'b1;
      r_wrn_s  <= 1'b1;
      r_wrn_d  <= 1'b1;
      r_rd_hi  <= 1'b0;
      r_rd_arm <= 1'b0;
      r_wr_hi  <= 1'b0;
      r_wr_arm <= 1'b0;
    end else begin
      r_rdn_d <= r_rdn_s;
      r_wrn_d <= r_wrn_s;
      if (cen) begin
        r_csn   <= cs_n;
        r_a0    <= a0;
        r_rdn_s <= cpu_rdn;
        r_wrn_s <= cpu_wrn;
        // A strobe only arms after a real high-then-low sequence following reset
        if (cpu_rdn) r_rd_hi <= 1'b1;
        else if (r_rd_hi) r_rd_arm <= 1'b1;
        if (cpu_wrn) r_wr_hi <= 1'b1;
        else if (r_wr_hi) r_wr_arm <= 1'b1;
      end
    end
  end

  assign w_rd_edge = r_rdn_s & ~r_rdn_d & r_rd_arm & ~r_csn;
  assign w_wr_edge = r_wrn_s & ~r_wrn_d & r_wr_arm & ~r_csn;

  // Input FIFO: host -> MCU, entries tagged with a0
  logic [DW:0]   r_ififo [DEPTH];
  logic [AW-1:0] r_iwp, r_irp;
  logic [CW-1:0] r_icnt;
  logic          w_ipop, w_ipush, w_idrop, w_ifull;

  assign w_ifull = (r_icnt == CW'(DEPTH));
  assign w_ipop  = mcu_rd & (r_icnt != '0);
  assign w_ipush = w_wr_edge & (~w_ifull | w_ipop);
  assign w_idrop = w_wr_edge & w_ifull & ~w_ipop;

  always_ff @(posedge clk) begin
    if (w_ipush) r_ififo[r_iwp] <= {r_a0, din};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_iwp  <= '0;
      r_irp  <= '0;
      r_icnt <= '0;
    end else begin
      if (w_ipush) r_iwp <= ptr_inc(r_iwp);
      if (w_ipop)  r_irp <= ptr_inc(r_irp);
      if (w_ipush && !w_ipop)      r_icnt <= r_icnt + CW'(1);
      else if (!w_ipush && w_ipop) r_icnt <= r_icnt - CW'(1);
    end
  end

  // Output FIFO: MCU -> host
  logic [DW-1:0] r_ofifo [DEPTH];
  logic [AW-1:0] r_owp, r_orp;
  logic [CW-1:0] r_ocnt;
  logic          w_opop, w_opush, w_ofull, w_obf;

  assign w_ofull = (r_ocnt == CW'(DEPTH));
  assign w_obf   = (r_ocnt != '0);
  assign w_opop  = w_rd_edge & ~r_a0 & w_obf;
  assign w_opush = mcu_wr & (~w_ofull | w_opop);

  always_ff @(posedge clk) begin
    if (w_opush) r_ofifo[r_owp] <= mcu_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owp  <= '0;
      r_orp  <= '0;
      r_ocnt <= '0;
    end else begin
      if (w_opush) r_owp <= ptr_inc(r_owp);
      if (w_opop)  r_orp <= ptr_inc(r_orp);
      if (w_opush && !w_opop)      r_ocnt <= r_ocnt + CW'(1);
      else if (!w_opush && w_opop) r_ocnt <= r_ocnt - CW'(1);
    end
  end

  // Flags: F1 follows the a0 of the last accepted host write
  logic r_f1, r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_f1  <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_idrop) begin
      r_ovf <= 1'b1;
    end else if (w_ipush) begin
      r_f1 <= r_a0;
      if (r_a0 && din == {DW{1'b1}}) r_ovf <= 1'b0;
    end
  end

  logic [DW-1:0] w_status;

  always_comb begin
    w_status              = '0;
    w_status[DW-1 -: STW] = mcu_st;
    w_status[3:0]         = {r_f1, mcu_f0, mcu_ibf, w_obf};
  end

  always_comb begin
    dout = '0;
    if (a0)         dout = w_status;
    else if (w_obf) dout = r_ofifo[r_orp];
  end

  assign mcu_ibf  = (r_icnt != '0);
  assign mcu_dout = r_ififo[r_irp][DW-1:0];
  assign mcu_cmd  = r_ififo[r_irp][DW];
  assign mcu_obf  = w_ofull;
  assign ovf      = r_ovf;

`ifdef JTFRAME_UPI_MBOX_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      host_irq <= 1'b0;
      mcu_irq  <= 1'b0;
    end else begin
      host_irq <= w_obf;
      mcu_irq  <= w_ipush;
    end
  end
`endif

endmodule

// File: doc/jtframe_upi_mbox.md
Name: jtframe_upi_mbox

Overview:
- Parametrised UPI-41/8742-style host mailbox: the host-bus data/status interface of an 8742, generalised.
- Adds per-direction FIFOs of configurable depth and width, and an MCU-writable user status nibble.
- Sits between a main CPU bus (a0/cs_n/rd/wr) and a soft MCU or FSM that services commands.
- Used where a protection MCU is replaced by HDL, or where more buffering than the single 8742 DBB is needed.

Parameters:
- DW, 8, data width of both FIFOs and host bus.
- DEPTH, 4, entries per FIFO; power of two, 1..64.
- STW, 4, width of MCU-written user status field placed in status[DW-1:DW-STW]; DW-STW must be >= 4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- cen  in  1  clock enable for host-strobe sampling
- a0  in  1  host address: 0 = data, 1 = status/command
- cs_n  in  1  host chip select, active low
- cpu_rdn  in  1  host read strobe, active low
- cpu_wrn  in  1  host write strobe, active low
- din  in  DW  host write data
- dout  out  DW  host read data
- mcu_rd  in  1  pop one entry from the input FIFO
- mcu_dout  out  DW  input FIFO head data
- mcu_cmd  out  1  a0 tag of the input FIFO head (1 = command write)
- mcu_ibf  out  1  input FIFO not empty
- mcu_wr  in  1  push mcu_din into the output FIFO
- mcu_din  in  DW  MCU output data
- mcu_obf  out  1  output FIFO full
- mcu_f0  in  1  F0 flag value
- mcu_st  in  STW  user status bits
- ovf  out  1  sticky: host write dropped because the input FIFO was full

Behaviour:
- Reset is synchronous on clk.
  - Both FIFOs are emptied and pointers cleared.
  - ovf=0, F1=0.
  - Strobe history registers are set to 1, so no spurious edge is seen after reset.
- Host strobe sampling:
  - cpu_rdn, cpu_wrn, cs_n and a0 are registered on clk when cen=1.
  - The registered values are then used for edge detection.
- Host write:
  - Occurs on a rising edge of cpu_wrn detected while the registered cs_n=0.
  - If the input FIFO is not full: push {a0, din}. F1 <= a0 in the same cycle.
  - If the input FIFO is full: data is dropped, ovf <= 1, F1 is unchanged.
- Host read:
  - dout is combinational. When a0=0, dout = output FIFO head, or 0 if that FIFO is empty.
  - When a0=1, dout = status.
  - status = {mcu_st, DW-STW-4 zero bits, F1, F0, IBF, OBF}:
    - bit0 OBF = output FIFO non-empty.
    - bit1 IBF = input FIFO non-empty.
    - bit2 = mcu_f0.
    - bit3 = F1.
  - A rising edge of cpu_rdn with cs_n=0 and a0=0 pops the output FIFO if it is non-empty.
  - A read of an empty FIFO or of status has no side effect.
- Edge timing: the push or pop takes effect on the clk edge after the edge is detected. Status reflects it the cycle after that, i.e. 1-cycle latency.
- MCU side:
  - mcu_rd pops when mcu_ibf=1. mcu_rd while empty is ignored.
  - mcu_wr pushes when the output FIFO is not full. mcu_wr while full is ignored, with no flag.
  - mcu_dout and mcu_cmd are valid whenever mcu_ibf=1.
- Simultaneous events:
  - A push and a pop on the same FIFO in one cycle are both performed and the count is unchanged.
  - On a full FIFO, a simultaneous push and pop is accepted. The full check uses the pre-pop count plus the pop.
- Pointer width is log2(DEPTH); pointers wrap naturally. The count register is log2(DEPTH)+1 bits.
- ovf is cleared only by rst, or by a host write of 0xFF-masked-to-DW-ones to a0=1. That command write also clears ovf but is still queued normally.
- rst asserted mid-transfer discards all FIFO contents. A strobe low across reset produces no edge after release until it has been seen high, then low, then high.

Optional Feature:
- Macro JTFRAME_UPI_MBOX_IRQ_EN.
- When defined, two extra outputs are added:
  - host_irq (1 bit): registered, equals OBF delayed one clk.
  - mcu_irq (1 bit): one-clk pulse on each push into the input FIFO.
- Both reset to 0.
- When undefined, these ports and their logic are absent and the remaining behaviour is identical.

Test Plan:
- Reset with cen=1, a0=1, read -> dout=0x00 (mst=0, f0=0), ovf=0, mcu_ibf=0.
- Host writes 0x12 at a0=0, then 0x34 at a0=1 -> mcu_ibf=1, mcu_dout=0x12 mcu_cmd=0. After mcu_rd: 0x34 mcu_cmd=1. Status bit3=1.
- DEPTH=4: host writes 5 bytes 0x01..0x05 -> ovf=1. MCU pops 0x01..0x04, then mcu_ibf=0.
- MCU pushes 0xA5, 0x5A -> status=0x01. Host reads a0=0 twice -> 0xA5 then 0x5A. Status then 0x00.
- Output FIFO full (4 entries), mcu_wr and host pop in the same cycle -> count stays 4. The new byte appears after the 3 remaining entries.
- With JTFRAME_UPI_MBOX_IRQ_EN: a host write produces mcu_irq high for exactly 1 clk. An MCU push raises host_irq 2 clks after mcu_wr.
